// File: rtl/tt_pkg.sv
// Shared types and sizes for the truth-table sweep checker.
package tt_pkg;

  localparam int unsigned TT_ROWS   = 16;
  localparam int unsigned TT_INPUTS = 4;

  typedef enum logic [2:0] {
    IDLE,
    DRIVE,
    SETTLE,
    SAMPLE,
    FINISH
  } tt_state_t;

endpackage

// File: rtl/tt_sync_edge.sv
// Two-flop synchroniser for the block-under-test output, plus a change flag
// comparing the synchronised level with its value one cycle earlier.
module tt_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic async_i,
  output logic level_o,
  output logic toggle_o
);

  logic [2:0] sync_q, sync_d;

  always_comb begin
    sync_d = {sync_q[1:0], async_i};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  // Bit 2 is only a history copy for change detection, not a third sync stage.
  assign level_o  = sync_q[1];
  assign toggle_o = sync_q[1] ^ sync_q[2];

endmodule

// File: rtl/tt_sweep_checker.sv
// Drives all 16 input rows into a combinational logic block, samples its output after a
// settle window and compares the captured truth table against an expected table.
module tt_sweep_checker
  import tt_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter int unsigned STABLE_WIN    = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [TT_ROWS-1:0]  tt_exp,
  input  logic                dut_out,
  output logic                in1,
  output logic                in2,
  output logic                in3,
  output logic                in4,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic [TT_ROWS-1:0]  observed,
  output logic [TT_ROWS-1:0]  mismatch,
  output logic [TT_ROWS-1:0]  unstable
);

  localparam logic [7:0] SettleInit = 8'(SETTLE_CYCLES);
  localparam logic [7:0] StableWin  = 8'(STABLE_WIN);
  localparam logic [3:0] LastRow    = 4'(TT_ROWS - 1);

  tt_state_t            state_q, state_d;
  logic [3:0]           row_q, row_d;
  logic [7:0]           cnt_q, cnt_d;
  logic [TT_ROWS-1:0]   exp_q, exp_d;
  logic [TT_INPUTS-1:0] in_q, in_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 pass_q, pass_d;
  logic [TT_ROWS-1:0]   observed_q, observed_d;
  logic [TT_ROWS-1:0]   mismatch_q, mismatch_d;
  logic [TT_ROWS-1:0]   unstable_q, unstable_d;

  logic sync_level;
  logic sync_toggle;

  tt_sync_edge u_sync (
    .clk      (clk),
    .rst      (rst),
    .async_i  (dut_out),
    .level_o  (sync_level),
    .toggle_o (sync_toggle)
  );

  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    cnt_d      = cnt_q;
    exp_d      = exp_q;
    in_d       = in_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    pass_d     = pass_q;
    observed_d = observed_q;
    mismatch_d = mismatch_q;
    unstable_d = unstable_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          exp_d      = tt_exp;
          observed_d = '0;
          mismatch_d = '0;
          unstable_d = '0;
          pass_d     = 1'b0;
          row_d      = '0;
          // Row 0 is presented while in DRIVE so the synchroniser has a head start.
          in_d       = '0;
          busy_d     = 1'b1;
          state_d    = DRIVE;
        end
      end
      DRIVE: begin
        cnt_d   = SettleInit;
        state_d = SETTLE;
      end
      SETTLE: begin
        if (cnt_q <= StableWin && sync_toggle) begin
          unstable_d[row_q] = 1'b1;
        end
        cnt_d = cnt_q - 8'd1;
        if (cnt_q == 8'd1) begin
          state_d = SAMPLE;
        end
      end
      SAMPLE: begin
        observed_d[row_q] = sync_level;
        mismatch_d[row_q] = sync_level ^ exp_q[row_q];
        if (row_q == LastRow) begin
          // Masks are final including this row, so pass is ready alongside done.
          pass_d  = (mismatch_d == '0) && (unstable_d == '0);
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = FINISH;
        end else begin
          row_d   = row_q + 4'd1;
          in_d    = row_q + 4'd1;
          state_d = DRIVE;
        end
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      row_q      <= '0;
      cnt_q      <= '0;
      exp_q      <= '0;
      in_q       <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      observed_q <= '0;
      mismatch_q <= '0;
      unstable_q <= '0;
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      cnt_q      <= cnt_d;
      exp_q      <= exp_d;
      in_q       <= in_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
      observed_q <= observed_d;
      mismatch_q <= mismatch_d;
      unstable_q <= unstable_d;
    end
  end

  assign {in4, in3, in2, in1} = in_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign pass     = pass_q;
  assign observed = observed_q;
  assign mismatch = mismatch_q;
  assign unstable = unstable_q;

endmodule

// File: tb/tb_tt_sweep_checker.sv
// Directed bench: two checker instances (default and minimum settle window), each driving a
// table-lookup stub of the logic block.
module tb_tt_sweep_checker;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Instance A: default parameters
  logic        start_a;
  logic [15:0] tt_exp_a;
  logic [15:0] model_a;
  logic        glitch_a;
  logic        dut_out_a;
  logic        in1_a, in2_a, in3_a, in4_a;
  logic        busy_a, done_a, pass_a;
  logic [15:0] observed_a, mismatch_a, unstable_a;
  logic [3:0]  row_in_a;

  assign row_in_a  = {in4_a, in3_a, in2_a, in1_a};
  assign dut_out_a = model_a[row_in_a] ^ glitch_a;

  tt_sweep_checker u_dut_a (
    .clk      (clk),
    .rst      (rst),
    .start    (start_a),
    .tt_exp   (tt_exp_a),
    .dut_out  (dut_out_a),
    .in1      (in1_a),
    .in2      (in2_a),
    .in3      (in3_a),
    .in4      (in4_a),
    .busy     (busy_a),
    .done     (done_a),
    .pass     (pass_a),
    .observed (observed_a),
    .mismatch (mismatch_a),
    .unstable (unstable_a)
  );

  // Instance B: shortest settle window
  logic        start_b;
  logic [15:0] tt_exp_b;
  logic [15:0] model_b;
  logic        dut_out_b;
  logic        in1_b, in2_b, in3_b, in4_b;
  logic        busy_b, done_b, pass_b;
  logic [15:0] observed_b, mismatch_b, unstable_b;
  logic [3:0]  row_in_b;

  assign row_in_b  = {in4_b, in3_b, in2_b, in1_b};
  assign dut_out_b = model_b[row_in_b];

  tt_sweep_checker #(
    .SETTLE_CYCLES (1),
    .STABLE_WIN    (1)
  ) u_dut_b (
    .clk      (clk),
    .rst      (rst),
    .start    (start_b),
    .tt_exp   (tt_exp_b),
    .dut_out  (dut_out_b),
    .in1      (in1_b),
    .in2      (in2_b),
    .in3      (in3_b),
    .in4      (in4_b),
    .busy     (busy_b),
    .done     (done_b),
    .pass     (pass_b),
    .observed (observed_b),
    .mismatch (mismatch_b),
    .unstable (unstable_b)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Start a sweep on A and wait for done; lat is inclusive of the start and done cycles.
  task automatic sweep_a(input logic [15:0] exp, output int lat, output bit to);
    int n;
    start_a  = 1'b1;
    tt_exp_a = exp;
    tick();
    start_a = 1'b0;
    n = 0;
    while (!done_a && n < 300) begin
      tick();
      n++;
    end
    to  = !done_a;
    lat = n + 2;
  endtask

  task automatic sweep_b(input logic [15:0] exp, output int lat, output bit to);
    int n;
    start_b  = 1'b1;
    tt_exp_b = exp;
    tick();
    start_b = 1'b0;
    n = 0;
    while (!done_b && n < 300) begin
      tick();
      n++;
    end
    to  = !done_b;
    lat = n + 2;
  endtask

  task automatic wait_row_a(input logic [3:0] row, output bit to);
    int n;
    n = 0;
    while (row_in_a !== row && n < 300) begin
      tick();
      n++;
    end
    to = (row_in_a !== row);
  endtask

  task automatic test_reset();
    int lat;
    bit to;
    logic [54:0] outs;
    rst = 1'b1;
    #1;
    outs = {busy_a, done_a, pass_a, row_in_a, observed_a, mismatch_a, unstable_a};
    checks++;
    if (outs !== 55'd0) begin
      errors++;
      $display("FAIL reset_init: got %h want 0", outs);
    end
    tick();
    rst = 1'b0;
    tick();
    model_a = 16'h5DA9;
    start_a  = 1'b1;
    tt_exp_a = 16'h5DA9;
    tick();
    start_a = 1'b0;
    wait_row_a(4'd7, to);
    checks++;
    if (to) begin
      errors++;
      $display("FAIL reset_reach_row7: timed out, got row %0d want 7", row_in_a);
    end
    tick();
    rst = 1'b1;
    #1;
    outs = {busy_a, done_a, pass_a, row_in_a, observed_a, mismatch_a, unstable_a};
    checks++;
    if (outs !== 55'd0) begin
      errors++;
      $display("FAIL reset_midsweep: got %h want 0", outs);
    end
    tick();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if ({busy_a, done_a} !== 2'b00) begin
        errors++;
        $display("FAIL reset_no_done: got busy/done %b want 00", {busy_a, done_a});
      end
    end
    sweep_a(16'h5DA9, lat, to);
    checks++;
    if (to || pass_a !== 1'b1 || observed_a !== 16'h5DA9 || unstable_a !== 16'h0) begin
      errors++;
      $display("FAIL reset_clean_sweep: got to=%0d pass=%b obs=%h unst=%h want 0 1 5da9 0000",
               to, pass_a, observed_a, unstable_a);
    end
    tick();
  endtask

  task automatic test_match();
    int lat;
    bit to;
    int n;
    model_a  = 16'h5DA9;
    start_a  = 1'b1;
    tt_exp_a = 16'h5DA9;
    tick();
    start_a = 1'b0;
    checks++;
    if (busy_a !== 1'b1 || row_in_a !== 4'h0) begin
      errors++;
      $display("FAIL match_busy_rise: got busy=%b row=%h want 1 0", busy_a, row_in_a);
    end
    n = 0;
    while (!done_a && n < 300) begin
      tick();
      n++;
    end
    to  = !done_a;
    lat = n + 2;
    // start cycle + 16 rows of (1 drive + 4 settle + 1 sample) + finish
    checks++;
    if (to || lat != 98) begin
      errors++;
      $display("FAIL match_latency: got %0d (to=%0d) want 98", lat, to);
    end
    checks++;
    if (busy_a !== 1'b0 || pass_a !== 1'b1) begin
      errors++;
      $display("FAIL match_flags: got busy=%b pass=%b want 0 1", busy_a, pass_a);
    end
    checks++;
    if (observed_a !== 16'h5DA9 || mismatch_a !== 16'h0 || unstable_a !== 16'h0) begin
      errors++;
      $display("FAIL match_masks: got obs=%h mis=%h unst=%h want 5da9 0000 0000",
               observed_a, mismatch_a, unstable_a);
    end
    checks++;
    if (row_in_a !== 4'hF) begin
      errors++;
      $display("FAIL match_hold_row: got %h want f", row_in_a);
    end
    tick();
    checks++;
    if (done_a !== 1'b0 || pass_a !== 1'b1 || row_in_a !== 4'hF) begin
      errors++;
      $display("FAIL match_after_done: got done=%b pass=%b row=%h want 0 1 f",
               done_a, pass_a, row_in_a);
    end
  endtask

  task automatic test_mismatch();
    int lat;
    bit to;
    model_a = 16'h5DA9;
    sweep_a(16'h5DA8, lat, to);
    checks++;
    if (to || pass_a !== 1'b0 || mismatch_a !== 16'h0001 || observed_a !== 16'h5DA9) begin
      errors++;
      $display("FAIL mismatch_row0: got to=%0d pass=%b mis=%h obs=%h want 0 0 0001 5da9",
               to, pass_a, mismatch_a, observed_a);
    end
    checks++;
    if (unstable_a !== 16'h0) begin
      errors++;
      $display("FAIL mismatch_unstable: got %h want 0000", unstable_a);
    end
    tick();
  endtask

  task automatic test_unstable();
    bit to;
    int n;
    model_a  = 16'h5DA9;
    start_a  = 1'b1;
    tt_exp_a = 16'h5DA9;
    tick();
    start_a = 1'b0;
    wait_row_a(4'd3, to);
    checks++;
    if (to) begin
      errors++;
      $display("FAIL unstable_reach_row3: timed out, got row %0d want 3", row_in_a);
    end
    // One-cycle glitch timed so its synchronised copy lands in the last settle cycle.
    tick();
    tick();
    glitch_a = 1'b1;
    tick();
    glitch_a = 1'b0;
    n = 0;
    while (!done_a && n < 300) begin
      tick();
      n++;
    end
    checks++;
    if (!done_a || unstable_a !== 16'h0008 || pass_a !== 1'b0) begin
      errors++;
      $display("FAIL unstable_row3: got done=%b unst=%h pass=%b want 1 0008 0",
               done_a, unstable_a, pass_a);
    end
    checks++;
    if (observed_a !== 16'h5DA9 || mismatch_a !== 16'h0) begin
      errors++;
      $display("FAIL unstable_obs: got obs=%h mis=%h want 5da9 0000", observed_a, mismatch_a);
    end
    tick();
  endtask

  task automatic test_busy_restart();
    int dones;
    bit p0, p5, pf;
    model_a  = 16'h5DA9;
    start_a  = 1'b1;
    tt_exp_a = 16'h5DA9;
    tick();
    start_a = 1'b0;
    dones = 0;
    p0 = 1'b0;
    p5 = 1'b0;
    pf = 1'b0;
    for (int i = 0; i < 140; i++) begin
      start_a = 1'b0;
      if (done_a) dones++;
      if (busy_a && row_in_a == 4'h0 && !p0) begin
        p0 = 1'b1;
        start_a = 1'b1;
        tt_exp_a = 16'h1234;
      end else if (busy_a && row_in_a == 4'h5 && !p5) begin
        p5 = 1'b1;
        start_a = 1'b1;
        tt_exp_a = 16'hFFFF;
      end else if (busy_a && row_in_a == 4'hF && !pf) begin
        pf = 1'b1;
        start_a = 1'b1;
        tt_exp_a = 16'h0000;
      end
      tick();
    end
    start_a = 1'b0;
    checks++;
    if (dones != 1 || !(p0 && p5 && pf)) begin
      errors++;
      $display("FAIL restart_single_done: got %0d dones (pulses %b%b%b) want 1 (111)",
               dones, p0, p5, pf);
    end
    checks++;
    if (pass_a !== 1'b1 || mismatch_a !== 16'h0 || observed_a !== 16'h5DA9 || busy_a !== 1'b0) begin
      errors++;
      $display("FAIL restart_result: got pass=%b mis=%h obs=%h busy=%b want 1 0000 5da9 0",
               pass_a, mismatch_a, observed_a, busy_a);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    bit to;
    model_b = 16'h3C5A;
    sweep_b(16'h3C5A, lat, to);
    // start cycle + 16 rows of (1 drive + 1 settle + 1 sample) + finish
    checks++;
    if (to || lat != 50) begin
      errors++;
      $display("FAIL b2b_latency1: got %0d (to=%0d) want 50", lat, to);
    end
    checks++;
    if (pass_b !== 1'b1 || observed_b !== 16'h3C5A || unstable_b !== 16'h0) begin
      errors++;
      $display("FAIL b2b_sweep1: got pass=%b obs=%h unst=%h want 1 3c5a 0000",
               pass_b, observed_b, unstable_b);
    end
    tick();
    sweep_b(16'hBC5B, lat, to);
    checks++;
    if (to || lat != 50) begin
      errors++;
      $display("FAIL b2b_latency2: got %0d (to=%0d) want 50", lat, to);
    end
    checks++;
    if (pass_b !== 1'b0 || observed_b !== 16'h3C5A || mismatch_b !== 16'h8001 ||
        unstable_b !== 16'h0) begin
      errors++;
      $display("FAIL b2b_sweep2: got pass=%b obs=%h mis=%h unst=%h want 0 3c5a 8001 0000",
               pass_b, observed_b, mismatch_b, unstable_b);
    end
    tick();
  endtask

  initial begin
    rst      = 1'b1;
    start_a  = 1'b0;
    tt_exp_a = 16'h0;
    model_a  = 16'h0;
    glitch_a = 1'b0;
    start_b  = 1'b0;
    tt_exp_b = 16'h0;
    model_b  = 16'h0;
    test_reset();
    test_match();
    test_mismatch();
    test_unstable();
    test_busy_restart();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
